mem_stage: RTL and testbench

Memory-access stage of the 16-bit pipeline. It consumes the EX/MEM pipeline register bundle and drives loads and stores onto a req/ack data-memory port. While an access is outstanding it stalls the upstream pipeline, resolves JEQ branches, and presents the write-back bundle to the MEM/WB register.

---
 rtl/mem_stage.sv | 112 +++++++++++
 tb/tb_mem_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: drives EX/MEM loads/stores onto a req/ack data port, stalls upstream
// while an access is outstanding, resolves JEQ. Optional abort timer: `define MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter logic [7:0] TIMEOUT = 8'd15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ControlsIn,
  input  logic [15:0] ResultIn,
  input  logic        ZeroIn,
  input  logic [15:0] DataIn,
  input  logic [15:0] MemAddrIn,
  input  logic [15:0] JEQAddrIn,
  input  logic [2:0]  Reg1In,
  output logic        MemReq,
  output logic        MemWe,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  input  logic [15:0] MemRData,
  input  logic        MemAck,
  output logic        Stall,
  output logic        BranchTaken,
  output logic [15:0] BranchTarget,
  output logic        WbRegWrite,
  output logic        WbMemToReg,
  output logic [15:0] WbResult,
  output logic [15:0] WbMemData,
  output logic [2:0]  WbReg,
  output logic        MemErr
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] load_q, load_d;

  logic reg_write, mem_to_reg, mem_read, mem_write, jeq;
  logic access, ack_ok, timeout;

  assign {reg_write, mem_to_reg, mem_read, mem_write, jeq} = ControlsIn;
  assign access = mem_read | mem_write;

  // Request is live in IDLE (issue cycle) and ACCESS; DONE is the guaranteed low cycle.
  assign MemReq = ~Reset & access & (state_q != DONE);
  assign Stall  = ~Reset & access & (state_q != DONE);
  assign ack_ok = MemReq & MemAck;

  assign MemWe        = mem_write & ~mem_read;
  assign MemAddr      = MemAddrIn;
  assign MemWData     = DataIn;
  assign BranchTaken  = jeq & ZeroIn;
  assign BranchTarget = JEQAddrIn;
  assign WbRegWrite   = reg_write & ~Stall;
  assign WbMemToReg   = mem_to_reg;
  assign WbResult     = ResultIn;
  assign WbMemData    = load_q;
  assign WbReg        = Reg1In;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       err_q, err_d;

  // Counter is held at zero outside ACCESS, so it restarts on every entry.
  assign cnt_inc = cnt_q + 8'd1;
  assign cnt_d   = (state_q == ACCESS) ? cnt_inc : 8'd0;
  assign timeout = (state_q == ACCESS) & ~ack_ok & ~Reset & (cnt_inc == TIMEOUT);
  assign err_d   = err_q | timeout;
  assign MemErr  = err_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
  assign MemErr         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    case (state_q)
      IDLE:    if (MemReq) state_d = ack_ok ? DONE : ACCESS;
      ACCESS:  if (ack_ok | timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An aborted read returns all-ones; writes never touch the load register.
    if (ack_ok & mem_read)
      load_d = MemRData;
    else if (timeout & mem_read)
      load_d = 16'hFFFF;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      load_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver queues expected outputs per cycle, monitor checks them.
module tb_mem_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ControlsIn;
  logic [15:0] ResultIn, DataIn, MemAddrIn, JEQAddrIn, MemRData;
  logic        ZeroIn, MemAck;
  logic [2:0]  Reg1In;
  logic        MemReq, MemWe, Stall, BranchTaken, WbRegWrite, WbMemToReg, MemErr;
  logic [15:0] MemAddr, MemWData, BranchTarget, WbResult, WbMemData;
  logic [2:0]  WbReg;

  mem_stage dut (
    .Clk(Clk), .Reset(Reset), .ControlsIn(ControlsIn), .ResultIn(ResultIn), .ZeroIn(ZeroIn),
    .DataIn(DataIn), .MemAddrIn(MemAddrIn), .JEQAddrIn(JEQAddrIn), .Reg1In(Reg1In),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .WbRegWrite(WbRegWrite), .WbMemToReg(WbMemToReg),
    .WbResult(WbResult), .WbMemData(WbMemData), .WbReg(WbReg), .MemErr(MemErr)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        req, we, stall, br, wbrw, wbm2r, err;
    logic [15:0] addr, wdata, btgt, res, wbdata;
    logic [2:0]  rg;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic cmp(input string nm, input string f, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got %h expected %h", nm, f, act, exp);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp(nm, "MemReq",       {15'd0, MemReq},      {15'd0, e.req});
      cmp(nm, "MemWe",        {15'd0, MemWe},       {15'd0, e.we});
      cmp(nm, "Stall",        {15'd0, Stall},       {15'd0, e.stall});
      cmp(nm, "BranchTaken",  {15'd0, BranchTaken}, {15'd0, e.br});
      cmp(nm, "WbRegWrite",   {15'd0, WbRegWrite},  {15'd0, e.wbrw});
      cmp(nm, "WbMemToReg",   {15'd0, WbMemToReg},  {15'd0, e.wbm2r});
      cmp(nm, "MemErr",       {15'd0, MemErr},      {15'd0, e.err});
      cmp(nm, "MemAddr",      MemAddr,      e.addr);
      cmp(nm, "MemWData",     MemWData,     e.wdata);
      cmp(nm, "BranchTarget", BranchTarget, e.btgt);
      cmp(nm, "WbResult",     WbResult,     e.res);
      cmp(nm, "WbMemData",    WbMemData,    e.wbdata);
      cmp(nm, "WbReg",        {13'd0, WbReg}, {13'd0, e.rg});
    end
  end

  // Queue the expected outputs for the inputs currently driven, then advance one cycle.
  task automatic chk(input string nm, input logic req, input logic we, input logic stall,
                     input logic wbrw, input logic br, input logic [15:0] wbdata, input logic err);
    exp_t e;
    e.req = req; e.we = we; e.stall = stall; e.br = br; e.wbrw = wbrw;
    e.wbm2r = ControlsIn[3]; e.err = err;
    e.addr = MemAddrIn; e.wdata = DataIn; e.btgt = JEQAddrIn; e.res = ResultIn;
    e.wbdata = wbdata; e.rg = Reg1In;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    ControlsIn = 5'd0; ResultIn = 16'd0; ZeroIn = 1'b0; DataIn = 16'd0; MemAddrIn = 16'd0;
    JEQAddrIn = 16'd0; Reg1In = 3'd0; MemRData = 16'd0; MemAck = 1'b0;
  endtask

  initial begin
    clr();
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("reset_zero", 0, 0, 0, 0, 0, 16'h0000, 0);
    ControlsIn = 5'b00100;
    chk("reset_forces_req", 0, 0, 0, 0, 0, 16'h0000, 0);
    Reset = 1'b0; clr();
    chk("idle_zero", 0, 0, 0, 0, 0, 16'h0000, 0);

    // Load acked in the first request cycle.
    ControlsIn = 5'b11100; MemAddrIn = 16'h0040; Reg1In = 3'd2; MemRData = 16'hBEEF; MemAck = 1;
    chk("load_c0", 1, 0, 1, 0, 0, 16'h0000, 0);
    MemAck = 0; MemRData = 16'h0000;
    chk("load_done", 0, 0, 0, 1, 0, 16'hBEEF, 0);
    clr(); ControlsIn = 5'b10000; ResultIn = 16'h5555; Reg1In = 3'd3;
    chk("alu_pass", 0, 0, 0, 1, 0, 16'hBEEF, 0);

    // Store with three wait cycles; read data on the port must not be captured.
    clr(); ControlsIn = 5'b00010; DataIn = 16'h1234; MemAddrIn = 16'h0080; MemRData = 16'hDEAD;
    for (int i = 0; i < 3; i++) chk("store_wait", 1, 1, 1, 0, 0, 16'hBEEF, 0);
    MemAck = 1;
    chk("store_ack", 1, 1, 1, 0, 0, 16'hBEEF, 0);
    MemAck = 0;
    chk("store_done", 0, 1, 0, 0, 0, 16'hBEEF, 0);

    // Stray ack with no request.
    clr(); MemAck = 1; MemRData = 16'h7777;
    chk("stray_ack", 0, 0, 0, 0, 0, 16'hBEEF, 0);
    clr();
    chk("stray_ack_after", 0, 0, 0, 0, 0, 16'hBEEF, 0);

    // Read and write both set: treated as a read.
    ControlsIn = 5'b10110; DataIn = 16'h5A5A; MemRData = 16'h0A0A; MemAck = 1;
    chk("rw_c0", 1, 0, 1, 0, 0, 16'hBEEF, 0);
    MemAck = 0;
    chk("rw_done", 0, 0, 0, 1, 0, 16'h0A0A, 0);
    // Back-to-back: next access issues right after DONE.
    clr(); ControlsIn = 5'b10100; MemAddrIn = 16'h0044; MemRData = 16'h1111; MemAck = 1;
    chk("b2b_c0", 1, 0, 1, 0, 0, 16'h0A0A, 0);
    MemAck = 0;
    chk("b2b_done", 0, 0, 0, 1, 0, 16'h1111, 0);

    // JEQ taken / not taken.
    clr(); ControlsIn = 5'b00001; ZeroIn = 1; JEQAddrIn = 16'h0100;
    chk("jeq_taken", 0, 0, 0, 0, 1, 16'h1111, 0);
    ZeroIn = 0;
    chk("jeq_not_taken", 0, 0, 0, 0, 0, 16'h1111, 0);

    // Reset in the second ACCESS cycle.
    clr(); ControlsIn = 5'b10100; MemAddrIn = 16'h0200;
    chk("rst_idle", 1, 0, 1, 0, 0, 16'h1111, 0);
    chk("rst_acc1", 1, 0, 1, 0, 0, 16'h1111, 0);
    Reset = 1;
    chk("rst_acc2", 0, 0, 0, 1, 0, 16'h1111, 0);
    Reset = 0; clr(); MemAck = 1; MemRData = 16'h9999;
    chk("rst_late_ack", 0, 0, 0, 0, 0, 16'h0000, 0);
    clr();
    chk("rst_after", 0, 0, 0, 0, 0, 16'h0000, 0);

`ifdef MEM_STAGE_TIMEOUT_EN
    // Read with no ack: abort in the 15th ACCESS cycle.
    ControlsIn = 5'b00100;
    chk("to_idle", 1, 0, 1, 0, 0, 16'h0000, 0);
    for (int i = 0; i < 15; i++) chk("to_access", 1, 0, 1, 0, 0, 16'h0000, 0);
    chk("to_done", 0, 0, 0, 0, 0, 16'hFFFF, 1);
    clr();
    chk("to_sticky", 0, 0, 0, 0, 0, 16'hFFFF, 1);
    Reset = 1;
    chk("to_reset", 0, 0, 0, 0, 0, 16'hFFFF, 1);
    Reset = 0;
    chk("to_cleared", 0, 0, 0, 0, 0, 16'h0000, 0);
    // Ack on the timeout cycle wins.
    ControlsIn = 5'b00100; MemRData = 16'h4321;
    chk("tack_idle", 1, 0, 1, 0, 0, 16'h0000, 0);
    for (int i = 0; i < 14; i++) chk("tack_access", 1, 0, 1, 0, 0, 16'h0000, 0);
    MemAck = 1;
    chk("tack_ack", 1, 0, 1, 0, 0, 16'h0000, 0);
    MemAck = 0;
    chk("tack_done", 0, 0, 0, 0, 0, 16'h4321, 0);
    clr();
    chk("tack_after", 0, 0, 0, 0, 0, 16'h4321, 0);
`endif

    @(posedge Clk); #1;
    cmp("end", "queue_left", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
